round_scheduler: RTL
====================

ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 SHALL have parameter NB_ROUNDS_MAX, default 12, number of rounds of the full permutation pa.
REQ-002 SHALL have port clock_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  synchronous active-high reset.
REQ-004 SHALL have port start_i  input  1  request to start one permutation run.
REQ-005 SHALL have port mode_i  input  2  run length: 2'b00 p12 (rounds 0..11), 2'b01 p6 (rounds 6..11), 2'b10 p8 (rounds 4..11, only when configured in), 2'b11 reserved.
REQ-006 SHALL have port hold_i  input  1  stall; freezes the run while high.
REQ-007 SHALL have port round_o  output  4  round index fed to the constant-addition stage.
REQ-008 SHALL have port en_state_o  output  1  state-register load enable for the permutation datapath.
REQ-009 SHALL have port sel_init_o  output  1  high during the first round of a run; selects the external state into the round.
REQ-010 SHALL have port busy_o  output  1  high while a run is in progress.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse after the last round has been loaded.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start_i=1 SHALL latch mode_i and go to RUN next cycle, with round_o = start round (0, 6 or 4); start_i=0 SHALL stay in IDLE.
REQ-014 RUN: en_state_o SHALL equal NOT hold_i; round_o SHALL increment by 1 per cycle with hold_i=0 and hold its value with hold_i=1.
REQ-015 sel_init_o SHALL be 1 only during the RUN cycles at the start round before the first non-held cycle completes, 0 otherwise.
REQ-016 RUN with round_o = NB_ROUNDS_MAX-1 and hold_i=0 SHALL go to DONE; round_o SHALL not wrap past NB_ROUNDS_MAX-1.
REQ-017 DONE: done_o=1 for exactly one cycle, en_state_o=0, busy_o=0; start_i=1 SHALL go directly to RUN (back-to-back run, no IDLE cycle), otherwise to IDLE.
REQ-018 busy_o SHALL be 1 exactly in RUN; start_i during RUN SHALL be ignored.
REQ-019 Latency SHALL be: start accepted at cycle T, done_o at cycle T+1+N+H, N = number of rounds, H = held cycles.
REQ-020 mode_i=2'b11, or 2'b10 with the p8 option not compiled, SHALL run as p12.
REQ-021 round_o SHALL be 0 in IDLE and DONE.

Reset
REQ-022 reset_i=1 SHALL force IDLE, round_o=0, en_state_o=0, sel_init_o=0, busy_o=0, done_o=0 at the next edge, including mid-run; no done_o for an aborted run.
REQ-023 reset_i SHALL take priority over start_i and hold_i.

Configuration
REQ-024 Macro ASCON_PB8_EN defined: mode 2'b10 SHALL run p8 (start round 4, 8 rounds).
REQ-025 Macro ASCON_PB8_EN undefined: mode 2'b10 SHALL behave as p12; no p8 logic compiled.

Structure
REQ-026 ascon_pack SHALL hold the FSM state enum, the mode encodings and the start-round constants; the round constant table stays in ascon_pack.
REQ-027 SHALL contain one sub-module, round_counter (4-bit loadable counter with enable), instantiated once; all else flat.

Verification
REQ-028 Reset, start_i=1 mode 00 -> round_o 0..11 on 12 consecutive cycles, sel_init_o=1 only on round 0, done_o at T+13.
REQ-029 mode 01 -> rounds 6..11, done_o at T+7; mode 10 with ASCON_PB8_EN -> rounds 4..11, done_o at T+9; without -> rounds 0..11.
REQ-030 hold_i=1 for 3 cycles at round 5 (mode 00) -> round_o stays 5, en_state_o=0 for those cycles, done_o at T+16.
REQ-031 start_i held high through DONE -> next run begins the cycle after done_o with round_o=0, busy_o low for exactly that DONE cycle.
REQ-032 reset_i=1 at round 7 -> next cycle all outputs 0, state IDLE, no done_o; start_i during RUN -> no restart, count unaffected.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon round scheduler: FSM states, run modes,
// start rounds and the round-constant table.
package ascon_pack;

    localparam int unsigned RND_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_P12  = 2'b00,
        MODE_P6   = 2'b01,
        MODE_P8   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam logic [RND_W-1:0] START_RND_P12 = 4'd0;
    localparam logic [RND_W-1:0] START_RND_P6  = 4'd6;
    localparam logic [RND_W-1:0] START_RND_P8  = 4'd4;

    // Round constant added to x2 in round r of the 12-round permutation.
    function automatic logic [7:0] round_const(input logic [RND_W-1:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd0:    rc = 8'hf0;
            4'd1:    rc = 8'he1;
            4'd2:    rc = 8'hd2;
            4'd3:    rc = 8'hc3;
            4'd4:    rc = 8'hb4;
            4'd5:    rc = 8'ha5;
            4'd6:    rc = 8'h96;
            4'd7:    rc = 8'h87;
            4'd8:    rc = 8'h78;
            4'd9:    rc = 8'h69;
            4'd10:   rc = 8'h5a;
            4'd11:   rc = 8'h4b;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/round_counter.sv
// Loadable round-index counter with increment enable; load wins over enable.
module round_counter
    import ascon_pack::*;
#(
    parameter int unsigned W = RND_W
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/round_scheduler.sv
// Round sequencer for the Ascon permutation (p12 / p6, and p8 when ASCON_PB8_EN is defined).
// Drives the round index, state-load enable and init select of the permutation datapath.
module round_scheduler
    import ascon_pack::*;
#(
    parameter int unsigned NB_ROUNDS_MAX = 12
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic             hold_i,
    output logic [RND_W-1:0] round_o,
    output logic             en_state_o,
    output logic             sel_init_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NB_ROUNDS_MAX - 1);

    state_e           state_q, state_d;
    logic             first_q, first_d;
    logic             cnt_load;
    logic             cnt_en;
    logic [RND_W-1:0] cnt_val;
    logic [RND_W-1:0] round_q;
    logic [RND_W-1:0] start_rnd;

    // Start round for the requested run; unknown modes fall back to the full p12.
    always_comb begin
        start_rnd = START_RND_P12;
        case (mode_e'(mode_i))
            MODE_P6: start_rnd = START_RND_P6;
`ifdef ASCON_PB8_EN
            MODE_P8: start_rnd = START_RND_P8;
`endif
            default: start_rnd = START_RND_P12;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_val    = '0;
        en_state_o = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    first_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = start_rnd;
                end else begin
                    state_d = ST_IDLE;
                    first_d = 1'b0;
                end
            end
            ST_RUN: begin
                en_state_o = ~hold_i;
                if (!hold_i) begin
                    first_d = 1'b0;
                    // Last round loaded: park the index at zero for DONE/IDLE.
                    if (round_q == LAST_RND) begin
                        state_d  = ST_DONE;
                        cnt_load = 1'b1;
                        cnt_val  = '0;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                first_d = 1'b0;
            end
        endcase
    end

    round_counter #(
        .W(RND_W)
    ) u_round_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .count_o    (round_q)
    );

    assign round_o    = round_q;
    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign sel_init_o = (state_q == ST_RUN) && first_q;

endmodule
